// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing controller: FSM state codes and
// the PWM full-scale helper.
package led_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  // Largest duty value representable with pwm_bits of resolution.
  function automatic int unsigned duty_max(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_breathe_pwm_gen.sv
// Free-running PWM with period-aligned duty reload and an active-low output.
// LED_BREATHE_GAMMA_EN selects a squared (perceptual) duty mapping at reload.
module pwm_gen
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                force_on,
  output logic                pwm_n,
  output logic                period_end
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] CNT_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] CNT_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] duty_q_r;
  logic [PWM_BITS-1:0] duty_map_s;
  logic                pwm_n_r;

`ifdef LED_BREATHE_GAMMA_EN
  // Upper half of the squared duty; full scale lands one below DUTY_MAX.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] lin);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lin} * {{PWM_BITS{1'b0}}, lin};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  assign duty_map_s = gamma_map(duty);
`else
  assign duty_map_s = duty;
`endif

  assign period_end = (pwm_cnt_r == DUTY_MAX);
  assign pwm_n      = pwm_n_r;

  // PWM counter, period-end duty reload and registered compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r <= CNT_ZERO;
      duty_q_r  <= CNT_ZERO;
      pwm_n_r   <= 1'b1;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + CNT_ONE;
      if (period_end) begin
        duty_q_r <= duty_map_s;
      end else begin
        duty_q_r <= duty_q_r;
      end
      pwm_n_r <= force_on ? 1'b0 : ~(pwm_cnt_r < duty_q_r);
    end
  end

endmodule

// File: rtl/led_breathe.sv
// LED breathing controller: ramps PWM duty up while trig is high and down
// while it is low. Optional gamma mapping via LED_BREATHE_GAMMA_EN.
module led_breathe
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  output logic                led_n,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] LVL_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] LVL_TOP   = DUTY_MAX - LVL_ONE;
  localparam logic [15:0]         STEP_LAST = 16'(STEP_DIV - 32'd1);

  logic [1:0]          state_r;
  logic [1:0]          state_s;
  logic [PWM_BITS-1:0] level_r;
  logic [PWM_BITS-1:0] level_s;
  logic [15:0]         step_cnt_r;
  logic [15:0]         step_cnt_s;
  logic [15:0]         step_adv_s;
  logic                busy_r;
  logic                period_end_s;
  logic                step_s;
  logic                force_on_s;

  assign step_s     = period_end_s && (step_cnt_r == STEP_LAST);
  assign force_on_s = (state_r == ST_ON);

  // Step timer advance, ignoring state changes.
  always_comb begin
    step_adv_s = step_cnt_r;
    if (period_end_s) begin
      step_adv_s = step_s ? 16'd0 : (step_cnt_r + 16'd1);
    end else begin
      step_adv_s = step_cnt_r;
    end
  end

  // Fade FSM: a trig change always beats a coincident step.
  always_comb begin
    state_s = state_r;
    level_s = level_r;
    case (state_r)
      ST_IDLE: begin
        level_s = LVL_ZERO;
        if (trig) begin
          state_s = ST_RISE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RISE: begin
        if (!trig) begin
          state_s = ST_FALL;
        end else if (step_s) begin
          if (level_r >= LVL_TOP) begin
            level_s = DUTY_MAX;
            state_s = ST_ON;
          end else begin
            level_s = level_r + LVL_ONE;
          end
        end else begin
          level_s = level_r;
        end
      end
      ST_ON: begin
        level_s = DUTY_MAX;
        if (!trig) begin
          state_s = ST_FALL;
        end else begin
          state_s = ST_ON;
        end
      end
      ST_FALL: begin
        if (trig) begin
          state_s = ST_RISE;
        end else if (step_s) begin
          if (level_r <= LVL_ONE) begin
            level_s = LVL_ZERO;
            state_s = ST_IDLE;
          end else begin
            level_s = level_r - LVL_ONE;
          end
        end else begin
          level_s = level_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        level_s = LVL_ZERO;
      end
    endcase
  end

  // Any state change restarts the step timer.
  always_comb begin
    step_cnt_s = step_adv_s;
    if (state_s != state_r) begin
      step_cnt_s = 16'd0;
    end else begin
      step_cnt_s = step_adv_s;
    end
  end

  // FSM, level, step timer and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      level_r    <= LVL_ZERO;
      step_cnt_r <= 16'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      level_r    <= level_s;
      step_cnt_r <= step_cnt_s;
      busy_r     <= (state_s == ST_RISE) || (state_s == ST_FALL);
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .duty      (level_r),
    .force_on  (force_on_s),
    .pwm_n     (led_n),
    .period_end(period_end_s)
  );

  assign level = level_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_led_breathe.sv
// Scoreboard bench for led_breathe (PWM_BITS=4, STEP_DIV=2) with a
// cycle-count reference model; honours LED_BREATHE_GAMMA_EN.
module tb_led_breathe;

  localparam int PB   = 4;
  localparam int SD   = 2;
  localparam int PER  = 16;
  localparam int DMAX = 15;

  localparam int M_IDLE = 0;
  localparam int M_RISE = 1;
  localparam int M_ON   = 2;
  localparam int M_FALL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       led_n;
  logic [3:0] level;
  logic       busy;

  typedef struct packed {
    logic       led_n;
    logic [3:0] level;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  // Reference model state, in spec terms.
  int m_cyc, m_pend, m_lvl, m_duty, m_mode;
  bit m_led;

  always #5 clk = ~clk;

  led_breathe #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .led_n(led_n),
    .level(level),
    .busy (busy)
  );

  function automatic int gamma(input int l);
`ifdef LED_BREATHE_GAMMA_EN
    return (l * l) >> PB;
`else
    return l;
`endif
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_edge(input bit r, input bit t);
    int pos;
    bit pe, stp;
    int nmode;
    exp_t e;
    if (r) begin
      m_cyc = 0; m_pend = 0; m_lvl = 0; m_duty = 0; m_mode = M_IDLE; m_led = 1'b1;
    end else begin
      pos   = m_cyc % PER;
      pe    = (pos == PER - 1);
      m_led = (m_mode == M_ON) ? 1'b0 : !(pos < m_duty);
      if (pe) m_duty = gamma(m_lvl);
      stp   = pe && ((m_pend % SD) == SD - 1);
      nmode = m_mode;
      case (m_mode)
        M_IDLE: if (t) nmode = M_RISE;
        M_RISE: begin
          if (!t) nmode = M_FALL;
          else if (stp) begin
            m_lvl = (m_lvl + 1 > DMAX) ? DMAX : m_lvl + 1;
            if (m_lvl == DMAX) nmode = M_ON;
          end
        end
        M_ON: if (!t) nmode = M_FALL;
        M_FALL: begin
          if (t) nmode = M_RISE;
          else if (stp) begin
            m_lvl = (m_lvl - 1 < 0) ? 0 : m_lvl - 1;
            if (m_lvl == 0) nmode = M_IDLE;
          end
        end
        default: nmode = M_IDLE;
      endcase
      if (pe) m_pend++;
      if (nmode != m_mode) m_pend = 0;
      m_mode = nmode;
      m_cyc++;
    end
    e.led_n = m_led;
    e.level = 4'(m_lvl);
    e.busy  = (m_mode == M_RISE) || (m_mode == M_FALL);
    sb_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit t);
    rst  = r;
    trig = t;
    @(posedge clk);
    model_edge(r, t);
    #1;
  endtask

  task automatic check_window(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d cycles, want %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard.
  initial begin
    exp_t e;
    while (!stim_done || sb_q.size() > 0) begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if ({led_n, level, busy} !== e) begin
          bad++;
          $display("FAIL out t=%0t: got led_n=%b level=%0d busy=%b, want led_n=%b level=%0d busy=%b",
                   $time, led_n, level, busy, e.led_n, e.level, e.busy);
        end
      end
    end
  end

  // Stimulus: directed fades, short pulse, then random trig/reset phases.
  initial begin
    int n;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);

    n = 0;
    do begin cyc(1'b0, 1'b1); n++; end while (level != 4'd15 && n < 600);
    check_window("rise_time", n, 464, 496);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1);

    n = 0;
    do begin cyc(1'b0, 1'b0); n++; end while (level != 4'd0 && n < 600);
    check_window("fall_time", n, 448, 496);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);

    cyc(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      bit t;
      int len;
      t   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 300);
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) cyc(1'b1, t);
      end
      for (int i = 0; i < len; i++) cyc(1'b0, t);
    end

    stim_done = 1'b1;
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
